// File: rtl/button_event_arbiter.sv
// Turns debounced button edges into press (and optionally release) events and
// serialises them round-robin over a valid/ready stream. Option macro: BTN_RELEASE_EVT_EN.
module button_event_arbiter #(
    parameter int N_BTN = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] lvl,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_press,
    output logic             overrun,
    input  logic             clr_overrun
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state_q, state_d;
    logic [N_BTN-1:0]   lvl_prev_q;
    logic [N_BTN-1:0]   pend_p_q, pend_p_d;
    logic [N_BTN-1:0]   rise, slot_pend, ld_oh, p_after;
    logic [IDX_W-1:0]   evt_idx_q, evt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   nxt_ptr, base, win, win_hi, win_lo;
    logic               any_pend, hi_found, load_en, ovr_set;
    logic               overrun_q, overrun_d;

    assign rise    = lvl & ~lvl_prev_q;
    assign nxt_ptr = (evt_idx_q == IDX_W'(N_BTN - 1)) ? '0 : evt_idx_q + 1'b1;
    assign base    = (state_q == OFFER) ? nxt_ptr : rr_ptr_q;

`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0] pend_r_q, pend_r_d, fall, ld_p, ld_r, r_after, cancel;
    logic             evt_press_q, evt_press_d;

    assign fall      = ~lvl & lvl_prev_q;
    assign slot_pend = pend_p_q | pend_r_q;
`else
    assign slot_pend = pend_p_q;
`endif

    // Round-robin: lowest pending index >= base, else lowest pending overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        hi_found = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (slot_pend[i]) begin
                win_lo = IDX_W'(i);
                if (IDX_W'(i) >= base) begin
                    win_hi   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win      = hi_found ? win_hi : win_lo;
        any_pend = |slot_pend;
    end

    always_comb begin
        state_d   = state_q;
        evt_idx_d = evt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        load_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    load_en   = 1'b1;
                    evt_idx_d = win;
                    state_d   = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    rr_ptr_d = nxt_ptr;
                    if (any_pend) begin
                        load_en   = 1'b1;
                        evt_idx_d = win;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_oh = '0;
        if (load_en) ld_oh[win] = 1'b1;
    end

`ifdef BTN_RELEASE_EVT_EN
    // A slot with both bits pending emits the press first; the release stays queued.
    assign ld_p    = ld_oh & pend_p_q;
    assign ld_r    = ld_oh & ~pend_p_q;
    assign p_after = pend_p_q & ~ld_p;
    assign r_after = pend_r_q & ~ld_r;
    // Re-press before the release went out: net level unchanged, drop the release.
    assign cancel  = rise & ~p_after & r_after;

    always_comb begin
        pend_p_d    = p_after | (rise & ~r_after);
        pend_r_d    = (r_after & ~cancel) | fall;
        ovr_set     = |((rise & p_after) | cancel | (fall & r_after));
        evt_press_d = load_en ? pend_p_q[win] : evt_press_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r_q    <= '0;
            evt_press_q <= 1'b0;
        end else begin
            pend_r_q    <= pend_r_d;
            evt_press_q <= evt_press_d;
        end
    end

    assign evt_press = evt_press_q;
`else
    assign p_after = pend_p_q & ~ld_oh;

    always_comb begin
        pend_p_d = p_after | rise;
        ovr_set  = |(rise & p_after);
    end

    assign evt_press = 1'b1;
`endif

    // Set beats clear so a merge in the clearing cycle is never lost.
    assign overrun_d = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lvl_prev_q <= '0;
            pend_p_q   <= '0;
            evt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_prev_q <= lvl;
            pend_p_q   <= pend_p_d;
            evt_idx_q  <= evt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_idx   = evt_idx_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus a random
// run compared cycle by cycle against a per-button pending-event model.
module tb_button_event_arbiter;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] lvl;
    logic         evt_valid, evt_ready, evt_press, overrun, clr_overrun;
    logic [W-1:0] evt_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int obs_idx[$];
    int obs_press[$];
    int obs_cyc[$];

    // model state
    bit m_pp[N];
    bit m_pr[N];
    bit m_prev[N];
    bit m_valid, m_press, m_ovr;
    int m_idx, m_rr;

    button_event_arbiter #(.N_BTN(N), .IDX_W(W)) dut (
        .clk(clk), .rst(rst), .lvl(lvl),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_idx(evt_idx), .evt_press(evt_press),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && evt_valid && evt_ready) begin
            obs_idx.push_back(int'(evt_idx));
            obs_press.push_back(int'(evt_press));
            obs_cyc.push_back(cyc);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pp[i] = 0; m_pr[i] = 0; m_prev[i] = 0;
        end
        m_valid = 0; m_press = 0; m_ovr = 0; m_idx = 0; m_rr = 0;
    endtask

    function automatic int pick(input int from);
        for (int k = 0; k < N; k++) begin
            int j = (from + k) % N;
            if (m_pp[j] || m_pr[j]) return j;
        end
        return -1;
    endfunction

    // What the next clock edge should do, given the inputs held across it.
    task automatic model_step(input logic [N-1:0] l, input logic rdy, input logic clr);
        int  got;
        bit  oset;
        got  = -1;
        oset = 0;
        if (!m_valid) begin
            got = pick(m_rr);
        end else if (rdy) begin
            m_rr = (m_idx + 1) % N;
            got  = pick(m_rr);
            if (got < 0) m_valid = 0;
        end
        if (got >= 0) begin
            m_valid = 1;
            m_idx   = got;
            if (m_pp[got]) begin m_press = 1; m_pp[got] = 0; end
            else           begin m_press = 0; m_pr[got] = 0; end
        end
        for (int i = 0; i < N; i++) begin
            bit r, f;
            r = l[i] && !m_prev[i];
            f = !l[i] && m_prev[i];
`ifdef BTN_RELEASE_EVT_EN
            if (r) begin
                if (m_pp[i])      oset = 1;
                else if (m_pr[i]) begin m_pr[i] = 0; oset = 1; end
                else              m_pp[i] = 1;
            end
            if (f) begin
                if (m_pr[i]) oset = 1;
                else         m_pr[i] = 1;
            end
`else
            if (r) begin
                if (m_pp[i]) oset = 1;
                else         m_pp[i] = 1;
            end
            if (f) m_prev[i] = m_prev[i];
`endif
            m_prev[i] = l[i];
        end
        if (oset)     m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic tick(input logic [N-1:0] l, input logic rdy, input logic clr);
        lvl = l; evt_ready = rdy; clr_overrun = clr;
        model_step(l, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; lvl = '0; evt_ready = 1'b0; clr_overrun = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (evt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", evt_idx); end
        for (int i = 0; i < 3; i++) begin
            tick('0, 1'b1, 1'b0);
            total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b exp=0", evt_valid); end
        end
    endtask

    task automatic test_single();
        int n0;
        do_reset();
        for (int i = 0; i < 9; i++) tick('0, 1'b1, 1'b0);
        n0 = obs_idx.size();
        tick(8'h08, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", evt_valid); end
        tick(8'h08, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b1 || evt_idx !== 3'd3 || evt_press !== 1'b1)
            begin bad++; $display("FAIL single_offer got v=%b i=%0d p=%b exp v=1 i=3 p=1", evt_valid, evt_idx, evt_press); end
        tick(8'h08, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", evt_valid); end
        for (int i = 0; i < 3; i++) tick(8'h08, 1'b1, 1'b0);
        total++; if (obs_idx.size() - n0 !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", obs_idx.size() - n0); end
        else begin
            total++; if (obs_idx[n0] !== 3) begin bad++; $display("FAIL single_idx got=%0d exp=3", obs_idx[n0]); end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL single_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_round_robin();
        int n0;
        int exp_i[3];
        exp_i = '{5, 6, 1};
        do_reset();
        for (int i = 0; i < 3; i++) tick(8'h02, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick('0, 1'b1, 1'b0);
        n0 = obs_idx.size();
        for (int i = 0; i < 6; i++) tick(8'h62, 1'b1, 1'b0);
        total++; if (obs_idx.size() - n0 !== 3) begin bad++; $display("FAIL rr_count got=%0d exp=3", obs_idx.size() - n0); end
        else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (obs_idx[n0 + k] !== exp_i[k]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, obs_idx[n0 + k], exp_i[k]); end
            end
            total++; if (obs_cyc[n0 + 2] - obs_cyc[n0] !== 2) begin bad++; $display("FAIL rr_b2b span got=%0d exp=2", obs_cyc[n0 + 2] - obs_cyc[n0]); end
        end
    endtask

    task automatic test_stall();
        int n0;
        do_reset();
        tick(8'h04, 1'b0, 1'b0);
        tick(8'h04, 1'b0, 1'b0);
        n0 = obs_idx.size();
        for (int i = 0; i < 20; i++) begin
            tick((i >= 2) ? 8'h84 : 8'h04, 1'b0, 1'b0);
            total++; if (evt_valid !== 1'b1 || evt_idx !== 3'd2 || evt_press !== 1'b1)
                begin bad++; $display("FAIL stall_hold c=%0d got v=%b i=%0d p=%b exp v=1 i=2 p=1", i, evt_valid, evt_idx, evt_press); end
        end
        for (int i = 0; i < 4; i++) tick(8'h84, 1'b1, 1'b0);
        total++; if (obs_idx.size() - n0 !== 2) begin bad++; $display("FAIL stall_count got=%0d exp=2", obs_idx.size() - n0); end
        else begin
            total++; if (obs_idx[n0] !== 2 || obs_idx[n0 + 1] !== 7)
                begin bad++; $display("FAIL stall_order got=%0d,%0d exp=2,7", obs_idx[n0], obs_idx[n0 + 1]); end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL stall_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        int n0, presses;
        do_reset();
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h11, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h11, 1'b0, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        total++; if (evt_valid !== 1'b1 || evt_idx !== 3'd0) begin bad++; $display("FAIL ovr_offer got v=%b i=%0d exp v=1 i=0", evt_valid, evt_idx); end
        n0 = obs_idx.size();
        for (int i = 0; i < 6; i++) tick(8'h11, 1'b1, 1'b0);
        presses = 0;
        for (int k = n0; k < obs_idx.size(); k++) if (obs_idx[k] == 4 && obs_press[k] == 1) presses++;
        total++; if (presses !== 1) begin bad++; $display("FAIL ovr_single_press got=%0d exp=1", presses); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        tick(8'h11, 1'b1, 1'b1);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        tick(8'h11, 1'b1, 1'b0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_stay_clear got=%b exp=0", overrun); end
    endtask

`ifdef BTN_RELEASE_EVT_EN
    task automatic test_release();
        int n0;
        do_reset();
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        n0 = obs_idx.size();
        for (int i = 0; i < 5; i++) tick(8'h00, 1'b1, 1'b0);
        total++; if (obs_idx.size() - n0 !== 2) begin bad++; $display("FAIL rel_count got=%0d exp=2", obs_idx.size() - n0); end
        else begin
            total++; if (obs_idx[n0] !== 0 || obs_press[n0] !== 1)
                begin bad++; $display("FAIL rel_first got i=%0d p=%0d exp i=0 p=1", obs_idx[n0], obs_press[n0]); end
            total++; if (obs_idx[n0 + 1] !== 0 || obs_press[n0 + 1] !== 0)
                begin bad++; $display("FAIL rel_second got i=%0d p=%0d exp i=0 p=0", obs_idx[n0 + 1], obs_press[n0 + 1]); end
        end
    endtask
`endif

    task automatic test_async_reset();
        int n0;
        do_reset();
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h0F, 1'b0, 1'b0);
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", evt_valid); end
        #2;
        rst = 1'b0; lvl = '0; evt_ready = 1'b1;
        model_reset();
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL arst_immediate got=%b exp=0", evt_valid); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        n0 = obs_idx.size();
        for (int i = 0; i < 8; i++) tick('0, 1'b1, 1'b0);
        total++; if (obs_idx.size() !== n0 || evt_valid !== 1'b0)
            begin bad++; $display("FAIL arst_no_events got=%0d v=%b exp=0 v=0", obs_idx.size() - n0, evt_valid); end
    endtask

    task automatic test_random();
        logic [N-1:0] l;
        logic         rdy, clr;
        do_reset();
        l = '0;
        for (int c = 0; c < 3000; c++) begin
            l   = l ^ N'($urandom & $urandom & $urandom);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            tick(l, rdy, clr);
            total++; if (evt_valid !== m_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, evt_valid, m_valid); end
            if (m_valid) begin
                total++; if (evt_idx !== W'(m_idx)) begin bad++; $display("FAIL rand_idx c=%0d got=%0d exp=%0d", c, evt_idx, m_idx); end
                total++; if (evt_press !== m_press) begin bad++; $display("FAIL rand_press c=%0d got=%b exp=%b", c, evt_press, m_press); end
            end
            total++; if (overrun !== m_ovr) begin bad++; $display("FAIL rand_overrun c=%0d got=%b exp=%b", c, overrun, m_ovr); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_overrun();
`ifdef BTN_RELEASE_EVT_EN
        test_release();
`endif
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects debounced button levels from up to N_BTN debounce channels and turns their edges into discrete press events.
- Arbitrates the events round-robin and serialises them over a valid/ready stream to the MIDI message builder, one event per accepted transfer.
- Sits between the per-button debouncers and the note/CC encoder.

Parameters:
- N_BTN, 8, number of button channels (2..32).
- IDX_W, 3, width of event index; must equal ceil(log2(N_BTN)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- lvl  in  N_BTN  debounced button levels; synchronous to clk; 1 = pressed.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a clk edge.
- evt_idx  out  IDX_W  button index of the offered event.
- evt_press  out  1  1 = press, 0 = release; tied 1 when the optional feature is off.
- overrun  out  1  sticky flag: an event was merged or dropped.
- clr_overrun  in  1  one-cycle pulse clears overrun.

Behaviour:
- Reset (rst low, asynchronous):
  - lvl_prev, all pending bits, overrun, evt_valid, evt_idx, evt_press and rr_ptr go to 0.
  - State goes to IDLE.
  - A button already high when reset releases produces a press event, because lvl_prev resets to 0.
- Edge detection: rise = lvl & ~lvl_prev; fall = ~lvl & lvl_prev; lvl_prev <= lvl every cycle.
- Press pending bit pend_p[i]:
  - Set on rise[i].
  - Cleared when the event is loaded into the output register.
- Merge on rise while pending:
  - If rise[i] occurs while pend_p[i] = 1 and i is not being loaded that cycle, the event merges (stays pending) and overrun is set.
  - If i is being loaded in the same cycle, pend_p[i] stays set and overrun is not set.
- Arbitration: pick the lowest pending index >= rr_ptr, wrapping modulo N_BTN.
- State machine, 2 states:
  - IDLE:
    - If any pending: load evt_idx/evt_press from the winner, clear that pending bit, evt_valid <= 1, go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - While evt_valid && !evt_ready: evt_valid, evt_idx and evt_press hold stable; evt_valid never drops without acceptance.
    - On acceptance: rr_ptr <= (evt_idx + 1) mod N_BTN.
    - If any pending bit is set that cycle, arbitrate from (evt_idx + 1) and load the next event (evt_valid stays 1, state stays OFFER).
    - Otherwise evt_valid <= 0, go to IDLE.
- Latency: lvl first sampled high at edge k -> pend set at edge k -> evt_valid high after edge k+1.
- Throughput: 1 event/cycle when evt_ready is held high.
- rr_ptr wraps from N_BTN-1 to 0.
- overrun:
  - Set by any merge/drop.
  - Cleared by clr_overrun.
  - Set wins over clear in the same cycle.
- A new edge on the button currently offered (already loaded) starts a new pending event; this is not an overrun.

Optional Feature:
- Macro: BTN_RELEASE_EVT_EN.
- Defined:
  - Adds a release pending bit pend_r[i], set on fall[i].
  - When both pend_p[i] and pend_r[i] are set, press is emitted first (evt_press = 1) and pend_r[i] stays pending, so the release follows.
  - A fall while pend_r[i] = 1 merges and sets overrun.
  - A rise while pend_r[i] = 1 and pend_p[i] = 0 (re-press before the release was sent) cancels pend_r[i], sets no pend_p, and sets overrun; the net level is unchanged since the last reported press.
  - Arbitration remains per button index; release and press of one button share one slot.
- Not defined:
  - No release tracking; evt_press is constant 1.
  - fall is ignored.

Test Plan:
- Reset, lvl = 0, then lvl[3] 0->1 at edge 10 with evt_ready = 1 -> evt_valid = 1 after edge 11, evt_idx = 3, evt_press = 1; one transfer, then evt_valid = 0; overrun = 0.
- lvl[1], lvl[5], lvl[6] rise on the same cycle with rr_ptr = 2, evt_ready = 1 -> consecutive transfers with idx 5, 6, 1 on 3 back-to-back cycles.
- evt_ready = 0 for 20 cycles with idx 2 offered -> evt_valid, evt_idx and evt_press remain constant for all 20 cycles; no other index appears.
- lvl[4] rises, falls, rises while evt_ready = 0 and another event is being offered -> single idx 4 press delivered, overrun = 1; clr_overrun pulse -> overrun = 0 next cycle.
- With BTN_RELEASE_EVT_EN: lvl[0] 1 then 0 while evt_ready = 0 -> after ready is raised: idx 0 press, then idx 0 release (evt_press = 0).
- Assert rst low during OFFER with 3 events pending -> evt_valid = 0 immediately (asynchronously), no events after rst release while lvl = 0.
